// File: rtl/instr_queue_decoder.sv
// Instruction FIFO with combinational decode of the head entry.
// Holds up to DEPTH 16-bit words and decodes the oldest one for the datapath.
module instr_queue_decoder #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   in,
  input  logic          load,
  input  logic          next,
  input  logic [2:0]    nsel,
  output logic          valid,
  output logic          full,
  output logic          ovf,
  output logic [CW-1:0] count,
  output logic [15:0]   instr,
  output logic [2:0]    opcode,
  output logic [1:0]    op,
  output logic [1:0]    ALUop,
  output logic [1:0]    shift,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic [W-1:0]  sximm5,
  output logic [W-1:0]  sximm8
);

  localparam int PW = $clog2(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;
  logic [15:0]   head;
  logic [2:0]    regsel;

  assign valid = (count_q != '0);
  assign full  = (count_q == CW'(DEPTH));
  assign ovf   = ovf_q;
  assign count = count_q;

  // A full queue still accepts a load when the head leaves on the same edge.
  always_comb begin
    push     = load & (~full | next);
    pop      = next & valid;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (load & full & ~next);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= in;
  end

  assign head  = valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign instr = head;

  always_comb begin
    regsel = 3'b000;
    case (nsel)
      3'b001:  regsel = head[2:0];
      3'b010:  regsel = head[7:5];
      3'b100:  regsel = head[10:8];
      default: regsel = 3'b000;
    endcase
  end

  assign opcode   = head[15:13];
  assign op       = head[12:11];
  assign ALUop    = head[12:11];
  assign shift    = head[4:3];
  assign readnum  = regsel;
  assign writenum = regsel;
  assign sximm5   = {{(W-5){head[4]}}, head[4:0]};
  assign sximm8   = {{(W-8){head[7]}}, head[7:0]};

endmodule

// File: tb/tb_instr_queue_decoder.sv
// Self-checking bench: directed steps plus random traffic against a queue-based model.
// A second instance with W=32 checks the wider sign extension on the same stimulus.
module tb_instr_queue_decoder;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in = 16'h0000;
  logic        load = 1'b0;
  logic        next = 1'b0;
  logic [2:0]  nsel = 3'b000;

  logic          valid, full, ovf;
  logic [CW-1:0] count;
  logic [15:0]   instr;
  logic [2:0]    opcode, readnum, writenum;
  logic [1:0]    op, ALUop, shift;
  logic [15:0]   sximm5, sximm8;

  logic          valid32, full32, ovf32;
  logic [CW-1:0] count32;
  logic [15:0]   instr32;
  logic [2:0]    opcode32, readnum32, writenum32;
  logic [1:0]    op32, ALUop32, shift32;
  logic [31:0]   sximm5_32, sximm8_32;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model_q[$];
  bit          model_ovf = 1'b0;

  always #5 clk = ~clk;

  instr_queue_decoder #(.W(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .next(next), .nsel(nsel),
    .valid(valid), .full(full), .ovf(ovf), .count(count), .instr(instr),
    .opcode(opcode), .op(op), .ALUop(ALUop), .shift(shift),
    .readnum(readnum), .writenum(writenum), .sximm5(sximm5), .sximm8(sximm8)
  );

  instr_queue_decoder #(.W(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .reset(reset), .in(in), .load(load), .next(next), .nsel(nsel),
    .valid(valid32), .full(full32), .ovf(ovf32), .count(count32), .instr(instr32),
    .opcode(opcode32), .op(op32), .ALUop(ALUop32), .shift(shift32),
    .readnum(readnum32), .writenum(writenum32), .sximm5(sximm5_32), .sximm8(sximm8_32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow directly from the queue contents and the decode rules.
  task automatic check_all(input string tag);
    logic [15:0] h;
    int          s5, s8, sel;
    h   = (model_q.size() != 0) ? model_q[0] : 16'h0000;
    s5  = h[4] ? int'(h[4:0]) - 32  : int'(h[4:0]);
    s8  = h[7] ? int'(h[7:0]) - 256 : int'(h[7:0]);
    sel = 0;
    if (nsel == 3'b001)      sel = int'(h[2:0]);
    else if (nsel == 3'b010) sel = int'(h[7:5]);
    else if (nsel == 3'b100) sel = int'(h[10:8]);
    check({tag, ".valid"},    32'(valid),    32'(model_q.size() != 0));
    check({tag, ".full"},     32'(full),     32'(model_q.size() == DEPTH));
    check({tag, ".ovf"},      32'(ovf),      32'(model_ovf));
    check({tag, ".count"},    32'(count),    32'(model_q.size()));
    check({tag, ".instr"},    32'(instr),    32'(h));
    check({tag, ".opcode"},   32'(opcode),   32'(h / 8192));
    check({tag, ".op"},       32'(op),       32'((h / 2048) % 4));
    check({tag, ".ALUop"},    32'(ALUop),    32'((h / 2048) % 4));
    check({tag, ".shift"},    32'(shift),    32'((h / 8) % 4));
    check({tag, ".readnum"},  32'(readnum),  32'(sel));
    check({tag, ".writenum"}, 32'(writenum), 32'(sel));
    check({tag, ".sximm5"},   32'(sximm5),   32'(s5 & 32'hFFFF));
    check({tag, ".sximm8"},   32'(sximm8),   32'(s8 & 32'hFFFF));
    check({tag, ".sximm5_w32"}, sximm5_32,   32'(s5));
    check({tag, ".sximm8_w32"}, sximm8_32,   32'(s8));
    check({tag, ".count_w32"},  32'(count32), 32'(model_q.size()));
  endtask

  task automatic step(input string tag, input bit rst, input bit ld, input logic [15:0] d,
                      input bit nx, input logic [2:0] ns);
    bit was_full, was_valid;
    @(negedge clk);
    reset = rst; load = ld; in = d; next = nx; nsel = ns;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      was_full  = (model_q.size() == DEPTH);
      was_valid = (model_q.size() != 0);
      if (nx && was_valid) void'(model_q.pop_front());
      if (ld && (!was_full || nx)) model_q.push_back(d);
      if (ld && was_full && !nx) model_ovf = 1'b1;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step("reset0", 1, 0, 16'h0, 0, 3'b000);

    // Basic decode of one word under each register select.
    step("tp1_load",  0, 1, 16'hD105, 0, 3'b100);
    step("tp1_rm",    0, 0, 16'h0,    0, 3'b001);
    step("tp1_rd",    0, 0, 16'h0,    0, 3'b010);
    step("tp1_none",  0, 0, 16'h0,    0, 3'b000);
    step("tp1_multi", 0, 0, 16'h0,    0, 3'b110);

    // Sign extension of imm5 and imm8.
    step("tp2_rst",   1, 0, 16'h0,    0, 3'b000);
    step("tp2_a01f",  0, 1, 16'hA01F, 0, 3'b010);
    step("tp2_pop",   0, 0, 16'h0,    1, 3'b010);
    step("tp2_d080",  0, 1, 16'hD080, 0, 3'b001);

    // Fill, overflow, drain.
    step("tp3_rst",   1, 0, 16'h0,    0, 3'b000);
    step("tp3_l1",    0, 1, 16'h1111, 0, 3'b100);
    step("tp3_l2",    0, 1, 16'h2222, 0, 3'b100);
    step("tp3_l3",    0, 1, 16'h3333, 0, 3'b100);
    step("tp3_l4",    0, 1, 16'h4444, 0, 3'b100);
    step("tp3_drop",  0, 1, 16'h5555, 0, 3'b100);
    for (int i = 0; i < 4; i++) step("tp3_drain", 0, 0, 16'h0, 1, 3'b001);
    step("tp3_underflow", 0, 0, 16'h0, 1, 3'b001);

    // Simultaneous load and next when full and when empty.
    for (int i = 1; i <= 4; i++) step("tp4_fill", 0, 1, 16'(i * 16'h1111), 0, 3'b010);
    step("tp4_full_both", 0, 1, 16'h5555, 1, 3'b010);
    for (int i = 0; i < 4; i++) step("tp4_drain", 0, 0, 16'h0, 1, 3'b010);
    step("tp4_empty_both", 0, 1, 16'h6666, 1, 3'b100);

    // Pointer wrap with two resident entries.
    step("tp5_rst", 1, 0, 16'h0, 0, 3'b000);
    step("tp5_pre", 0, 1, 16'hF000, 0, 3'b001);
    step("tp5_pre", 0, 1, 16'hF001, 0, 3'b001);
    for (int k = 0; k < 10; k++) begin
      step("tp5_load", 0, 1, 16'(16'h0A00 + k), 0, 3'b001);
      step("tp5_next", 0, 0, 16'h0, 1, 3'b001);
      check("tp5_max3", 32'(count <= 3), 32'd1);
    end

    // Reset mid-operation overrides load and next.
    for (int i = 0; i < 4; i++) step("tp6_fill", 0, 1, 16'(16'h7000 + i), 0, 3'b010);
    step("tp6_ovf",  0, 1, 16'h7777, 0, 3'b010);
    step("tp6_pop",  0, 0, 16'h0,    1, 3'b010);
    step("tp6_rst",  1, 1, 16'h9999, 1, 3'b010);
    step("tp6_load", 0, 1, 16'h1234, 0, 3'b010);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), bit'($urandom_range(0, 2) != 0),
           16'($urandom), bit'($urandom_range(0, 1)), 3'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
